tank_motion_controller: RTL and testbench
=========================================

TANK_MOTION_CONTROLLER -- requirements
Module: tank_motion_controller

Interface
REQ-001 The block SHALL have one clock, CLOCK_50; reset is synchronous and active-high on port reset.
REQ-002 Parameter TICK_DIV, default 833333, SHALL set the CLOCK_50 cycles per movement tick (60 Hz).
REQ-003 Parameter X_MAX, default 152, SHALL set the largest legal tank_x.
REQ-004 Parameter Y_MAX, default 112, SHALL set the largest legal tank_y.
REQ-005 Parameter X_INIT, default 8, SHALL set the tank_x reset value.
REQ-006 Parameter Y_INIT, default 56, SHALL set the tank_y reset value.
REQ-007 Parameter H_INIT, default 2'b01, SHALL set the heading reset value.
REQ-008 Parameter COOLDOWN, default 30, SHALL set the ticks between accepted shots.
REQ-009 Ports SHALL be:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous active-high reset
- up, down, left, right  in  1 each  held-key levels from the keyboard decoder
- fire  in  1  held fire-key level
- shot_ack  in  1  bullet engine accepts the shot
- tank_x  out  8  tank column (top-left)
- tank_y  out  7  tank row (top-left)
- heading  out  2  00 up, 01 right, 10 down, 11 left
- moving  out  1  high when the last tick moved the tank
- shot_req  out  1  shot request
- shot_x  out  8, shot_y  out  7, shot_dir  out  2  shot origin and direction, valid while shot_req=1

Function
REQ-010 Tick counter SHALL count 0..TICK_DIV-1 and wrap; internal tick SHALL be high for exactly one cycle when the counter equals TICK_DIV-1.
REQ-011 The first tick SHALL occur TICK_DIV cycles after the first cycle with reset low.
REQ-012 On a tick, the direction SHALL be chosen by priority up > down > left > right; non-tick cycles SHALL leave tank_x, tank_y, heading and moving unchanged.
REQ-013 On a tick with a direction chosen, heading SHALL take that direction, even if the step is blocked.
REQ-014 Step SHALL be 1 pixel: up decrements tank_y, down increments tank_y, left decrements tank_x, right increments tank_x.
REQ-015 Steps SHALL saturate: no decrement at 0, no increment of tank_x at X_MAX or tank_y at Y_MAX; position SHALL never leave 0..X_MAX / 0..Y_MAX.
REQ-016 moving SHALL be set to 1 on a tick that changes position and 0 on any other tick (blocked or no key).
REQ-017 Updates SHALL be registered: values take effect on the cycle after the tick.
REQ-018 Fire FSM SHALL have states READY, REQ and COOL.
REQ-019 READY: if fire=1, capture shot_x=tank_x, shot_y=tank_y, shot_dir=heading (current register values, pre-update if a tick occurs the same cycle) and go to REQ.
REQ-020 REQ: shot_req=1 and shot_x/y/dir held stable; on shot_ack=1 go to COOL with cooldown counter loaded with COOLDOWN; fire and ticks SHALL be ignored for capture.
REQ-021 COOL: decrement counter on each tick; on a tick with counter==1 go to READY; COOLDOWN=0 SHALL go directly from REQ to READY.
REQ-022 shot_req SHALL be high only in REQ; holding fire SHALL produce repeated shots spaced by the cooldown.
REQ-023 shot_ack outside REQ SHALL be ignored.
REQ-024 Movement SHALL continue independently of fire FSM state.

Reset
REQ-025 reset SHALL override all activity in the same edge: tank_x=X_INIT, tank_y=Y_INIT, heading=H_INIT, moving=0, shot_req=0, shot_x=0, shot_y=0, shot_dir=0, fire FSM=READY, tick and cooldown counters=0.
REQ-026 reset asserted mid-REQ or mid-COOL SHALL drop shot_req on the next cycle with no shot retained.

Verification (bench params TICK_DIV=4, COOLDOWN=3, defaults otherwise)
REQ-027 Hold right 5 ticks from reset -> tank_x 8,9,10,11,12,13 one cycle after each tick; heading=01; moving=1.
REQ-028 tank_x=0, hold left one tick -> tank_x stays 0, heading=11, moving=0.
REQ-029 up and right held together -> tank_y decrements, tank_x unchanged, heading=00.
REQ-030 fire pulse at (8,56), heading 01; shot_ack after 5 cycles -> shot_req high exactly those cycles with shot=(8,56,01); no new shot until 3 ticks later.
REQ-031 fire held continuously with shot_ack tied high -> shot_req pulses once, then once every 3 ticks.
REQ-032 reset during REQ with tank at (20,30) -> next cycle shot_req=0, position (8,56), heading=01.

Source files
------------

// File: rtl/tank_motion_controller.sv
// Tank position/heading stepper driven by a divided movement tick, plus a fire
// FSM that offers one shot at a time and enforces a tick-based cooldown.
module tank_motion_controller #(
  parameter int         TICK_DIV = 833333,
  parameter int         X_MAX    = 152,
  parameter int         Y_MAX    = 112,
  parameter int         X_INIT   = 8,
  parameter int         Y_INIT   = 56,
  parameter logic [1:0] H_INIT   = 2'b01,
  parameter int         COOLDOWN = 30
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic       fire,
  input  logic       shot_ack,
  output logic [7:0] tank_x,
  output logic [6:0] tank_y,
  output logic [1:0] heading,
  output logic       moving,
  output logic       shot_req,
  output logic [7:0] shot_x,
  output logic [6:0] shot_y,
  output logic [1:0] shot_dir
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [7:0] X_LIM = 8'(X_MAX);
  localparam logic [6:0] Y_LIM = 7'(Y_MAX);
  localparam logic [1:0] H_UP = 2'b00, H_RIGHT = 2'b01, H_DOWN = 2'b10, H_LEFT = 2'b11;

  typedef enum logic [1:0] {ST_READY, ST_REQ, ST_COOL} fire_state_e;

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          tick;
  logic [7:0]    x_q, x_d;
  logic [6:0]    y_q, y_d;
  logic [1:0]    h_q, h_d;
  logic          mv_q, mv_d;
  fire_state_e   state_q, state_d;
  logic [CW-1:0] cd_q, cd_d;
  logic [7:0]    sx_q, sx_d;
  logic [6:0]    sy_q, sy_d;
  logic [1:0]    sd_q, sd_d;

  assign tick = (tick_cnt_q == TICK_LAST);

  always_comb begin
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
  end

  // Heading follows the chosen key even when the step itself is blocked at an edge.
  always_comb begin
    x_d  = x_q;
    y_d  = y_q;
    h_d  = h_q;
    mv_d = mv_q;
    if (tick) begin
      mv_d = 1'b0;
      if (up) begin
        h_d = H_UP;
        if (y_q != 7'd0) begin
          y_d  = y_q - 7'd1;
          mv_d = 1'b1;
        end
      end else if (down) begin
        h_d = H_DOWN;
        if (y_q < Y_LIM) begin
          y_d  = y_q + 7'd1;
          mv_d = 1'b1;
        end
      end else if (left) begin
        h_d = H_LEFT;
        if (x_q != 8'd0) begin
          x_d  = x_q - 8'd1;
          mv_d = 1'b1;
        end
      end else if (right) begin
        h_d = H_RIGHT;
        if (x_q < X_LIM) begin
          x_d  = x_q + 8'd1;
          mv_d = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    cd_d     = cd_q;
    sx_d     = sx_q;
    sy_d     = sy_q;
    sd_d     = sd_q;
    shot_req = 1'b0;
    case (state_q)
      ST_READY: begin
        // Capture uses the pre-tick position so the shot matches what was on screen.
        if (fire) begin
          sx_d    = x_q;
          sy_d    = y_q;
          sd_d    = h_q;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        shot_req = 1'b1;
        if (shot_ack) begin
          cd_d    = CW'(COOLDOWN);
          state_d = (COOLDOWN == 0) ? ST_READY : ST_COOL;
        end
      end
      ST_COOL: begin
        if (tick) begin
          if (cd_q <= CW'(1)) begin
            cd_d    = '0;
            state_d = ST_READY;
          end else begin
            cd_d = cd_q - CW'(1);
          end
        end
      end
      default: state_d = ST_READY;
    endcase
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      tick_cnt_q <= '0;
      x_q        <= 8'(X_INIT);
      y_q        <= 7'(Y_INIT);
      h_q        <= H_INIT;
      mv_q       <= 1'b0;
      state_q    <= ST_READY;
      cd_q       <= '0;
      sx_q       <= 8'd0;
      sy_q       <= 7'd0;
      sd_q       <= 2'd0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
      x_q        <= x_d;
      y_q        <= y_d;
      h_q        <= h_d;
      mv_q       <= mv_d;
      state_q    <= state_d;
      cd_q       <= cd_d;
      sx_q       <= sx_d;
      sy_q       <= sy_d;
      sd_q       <= sd_d;
    end
  end

  assign tank_x   = x_q;
  assign tank_y   = y_q;
  assign heading  = h_q;
  assign moving   = mv_q;
  assign shot_x   = sx_q;
  assign shot_y   = sy_q;
  assign shot_dir = sd_q;

endmodule

// File: tb/tb_tank_motion_controller.sv
// Scoreboard bench: expected positions and shots are queued as stimulus is
// driven and consumed by a negedge monitor as the DUT produces them.
module tb_tank_motion_controller;

  localparam int TB_DIV = 4;

  logic       CLOCK_50 = 1'b0;
  logic       reset = 1'b1;
  logic       up = 1'b0, down = 1'b0, left = 1'b0, right = 1'b0;
  logic       fire = 1'b0, shot_ack = 1'b0;
  logic [7:0] tank_x, shot_x;
  logic [6:0] tank_y, shot_y;
  logic [1:0] heading, shot_dir;
  logic       moving, shot_req;

  tank_motion_controller #(.TICK_DIV(TB_DIV), .COOLDOWN(3)) dut (
    .CLOCK_50(CLOCK_50), .reset(reset),
    .up(up), .down(down), .left(left), .right(right),
    .fire(fire), .shot_ack(shot_ack),
    .tank_x(tank_x), .tank_y(tank_y), .heading(heading), .moving(moving),
    .shot_req(shot_req), .shot_x(shot_x), .shot_y(shot_y), .shot_dir(shot_dir)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    logic [16:0] org;
    int          len;
    int          sp;
  } shot_t;

  logic [17:0] pq[$];
  shot_t       sq[$];
  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, required 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Edge classification tracked from the bench's own view of the tick period.
  int   tb_cyc = 0;
  int   ticks_since = 0;
  logic started = 1'b0, e_reset = 1'b0, e_tick = 1'b0, ack_seen = 1'b0;

  always @(posedge CLOCK_50) begin
    if (reset) begin
      tb_cyc   <= 0;
      started  <= 1'b1;
      ack_seen <= 1'b0;
    end else begin
      tb_cyc <= (tb_cyc == TB_DIV - 1) ? 0 : tb_cyc + 1;
      if (shot_req && shot_ack) begin
        ack_seen    <= 1'b1;
        ticks_since <= 0;
      end else if (tb_cyc == TB_DIV - 1) begin
        ticks_since <= ticks_since + 1;
      end
    end
    e_reset <= reset;
    e_tick  <= !reset && (tb_cyc == TB_DIV - 1);
  end

  logic [17:0] hold = {8'd8, 7'd56, 2'b01, 1'b0};
  logic [17:0] exp_p;
  logic        prev_req = 1'b0;
  int          req_len = 0;
  shot_t       cur;

  initial begin
    forever begin
      @(negedge CLOCK_50);
      if (started) begin
        if (e_reset) begin
          hold = {8'd8, 7'd56, 2'b01, 1'b0};
          chk("rst_pos", {tank_x, tank_y, heading, moving}, hold);
          chk("rst_shot", {shot_req, shot_x, shot_y, shot_dir}, 32'd0);
          prev_req = 1'b0;
        end else begin
          if (e_tick) begin
            if (pq.size() != 0) exp_p = pq.pop_front();
            else exp_p = {hold[17:1], 1'b0};
            chk("tick_pos", {tank_x, tank_y, heading, moving}, exp_p);
            hold = exp_p;
          end else begin
            chk("hold_pos", {tank_x, tank_y, heading, moving}, hold);
          end
          if (shot_req && !prev_req) begin
            chk("shot_queued", sq.size() != 0, 1);
            if (sq.size() != 0) begin
              cur = sq.pop_front();
              chk("shot_org", {shot_x, shot_y, shot_dir}, cur.org);
              if (cur.sp != 0) chk("shot_gap_ticks", ack_seen ? ticks_since : -1, cur.sp);
            end else begin
              cur = '{org: 17'd0, len: 0, sp: 0};
            end
            req_len = 1;
          end else if (shot_req) begin
            req_len++;
            chk("shot_stable", {shot_x, shot_y, shot_dir}, cur.org);
          end else if (prev_req && cur.len != 0) begin
            chk("req_len", req_len, cur.len);
          end
          prev_req = shot_req;
        end
      end
    end
  end

  logic [7:0] mx = 8'd8;
  logic [6:0] my = 7'd56;
  logic [1:0] mh = 2'b01;
  logic       mv = 1'b0;

  task automatic model_step(input logic u, input logic d, input logic l, input logic r);
    mv = 1'b0;
    if (u) begin
      mh = 2'b00;
      if (my != 7'd0) begin my = my - 7'd1; mv = 1'b1; end
    end else if (d) begin
      mh = 2'b10;
      if (my != 7'd112) begin my = my + 7'd1; mv = 1'b1; end
    end else if (l) begin
      mh = 2'b11;
      if (mx != 8'd0) begin mx = mx - 8'd1; mv = 1'b1; end
    end else if (r) begin
      mh = 2'b01;
      if (mx != 8'd152) begin mx = mx + 8'd1; mv = 1'b1; end
    end
    pq.push_back({mx, my, mh, mv});
  endtask

  task automatic move(input logic u, input logic d, input logic l, input logic r);
    model_step(u, d, l, r);
    up = u; down = d; left = l; right = r;
    for (int i = 0; i < 40 && pq.size() != 0; i++) @(negedge CLOCK_50);
    if (pq.size() != 0) begin
      chk("move_timeout", pq.size(), 0);
      pq.delete();
    end
    up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) @(negedge CLOCK_50);
    reset = 1'b0;
    mx = 8'd8; my = 7'd56; mh = 2'b01; mv = 1'b0;
  endtask

  initial begin
    fork
      begin
        #500000;
        $display("FAIL watchdog: run did not complete, compared %0d", n_cmp);
        $fatal(1);
      end
    join_none

    do_reset();
    repeat (5) move(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (14) move(1'b0, 1'b0, 1'b1, 1'b0);
    move(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) move(1'b1, 1'b0, 1'b0, 1'b1);
    repeat (153) move(1'b0, 1'b0, 1'b0, 1'b1);

    // Fire lands on a tick edge while the tank steps right: origin is pre-step.
    do_reset();
    for (int i = 0; i < 10 && tb_cyc != TB_DIV - 1; i++) @(negedge CLOCK_50);
    sq.push_back('{org: {8'd8, 7'd56, 2'b01}, len: 5, sp: 0});
    sq.push_back('{org: {8'd9, 7'd56, 2'b01}, len: 1, sp: 3});
    sq.push_back('{org: {8'd9, 7'd56, 2'b01}, len: 1, sp: 3});
    model_step(1'b0, 1'b0, 1'b0, 1'b1);
    right = 1'b1;
    fire = 1'b1;
    @(negedge CLOCK_50);
    right = 1'b0;
    repeat (4) @(negedge CLOCK_50);
    shot_ack = 1'b1;
    for (int i = 0; i < 200 && sq.size() != 0; i++) @(negedge CLOCK_50);
    if (sq.size() != 0) chk("shot_timeout", sq.size(), 0);
    fire = 1'b0;
    repeat (2) @(negedge CLOCK_50);
    shot_ack = 1'b0;
    repeat (16) @(negedge CLOCK_50);

    // Reset while a shot is pending at (20,30).
    repeat (11) move(1'b0, 1'b0, 1'b0, 1'b1);
    repeat (26) move(1'b1, 1'b0, 1'b0, 1'b0);
    sq.push_back('{org: {8'd20, 7'd30, 2'b00}, len: 0, sp: 0});
    fire = 1'b1;
    @(negedge CLOCK_50);
    fire = 1'b0;
    @(negedge CLOCK_50);
    reset = 1'b1;
    @(negedge CLOCK_50);
    reset = 1'b0;
    mx = 8'd8; my = 7'd56; mh = 2'b01; mv = 1'b0;
    repeat (20) @(negedge CLOCK_50);
    chk("shots_left", sq.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
